// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: in-order result buffer, branch redirect with
// wrong-path squash, and forwarding of the youngest buffered result.
module ex_wb_stage #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic [4:0]                 ex_opcode,
  input  logic [6:0]                 ex_rd,
  input  logic [6:0]                 ex_branch,
  input  logic [DATA_W-1:0]          ex_result,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [6:0]                 wb_rd,
  output logic [DATA_W-1:0]          wb_data,
  output logic [4:0]                 wb_opcode,
  output logic                       redirect,
  output logic [6:0]                 redirect_pc,
  output logic                       flush,
  output logic                       fwd_valid,
  output logic [6:0]                 fwd_rd,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_illegal
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SQ_W  = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_B   = 5'd7;
  localparam logic [4:0] OP_BEG = 5'd8;
  localparam logic [4:0] OP_MAX = 5'd10;

  typedef enum logic {S_IDLE, S_SQUASH} state_t;

  typedef struct packed {
    logic [6:0]        rd;
    logic [DATA_W-1:0] data;
    logic [4:0]        op;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  state_t           r_state, w_state_nxt;
  logic [SQ_W-1:0]  r_sq_cnt, w_sq_nxt;
  logic             r_redirect;
  logic [6:0]       r_redirect_pc;
  logic             r_err;

  logic             w_flush, w_xfer, w_live, w_push, w_pop, w_take, w_illegal;
  logic             w_enq_op;
  logic [PTR_W-1:0] w_yidx;
  entry_t           w_head, w_young;

  assign w_flush  = (r_state == S_SQUASH);
  assign ex_ready = w_flush | (r_count < CNT_W'(DEPTH));
  assign w_xfer   = ex_valid & ex_ready;
  assign w_live   = w_xfer & ~w_flush;

  // Opcodes 1-6, 9 and 10 carry a register result; 11 and above are illegal.
  assign w_enq_op  = (ex_opcode != OP_NOP) && (ex_opcode != OP_B) &&
                     (ex_opcode != OP_BEG) && (ex_opcode <= OP_MAX);
  assign w_push    = w_live & w_enq_op;
  assign w_take    = w_live & ((ex_opcode == OP_B) ||
                               ((ex_opcode == OP_BEG) && (ex_branch != 7'd0)));
  assign w_illegal = w_live & (ex_opcode > OP_MAX);
  assign w_pop     = (r_count != '0) & wb_ready;

  // Squash FSM: counts accepted wrong-path transfers after a taken branch.
  always_comb begin
    w_state_nxt = r_state;
    w_sq_nxt    = r_sq_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt = S_SQUASH;
          w_sq_nxt    = SQ_W'(FLUSH_CYCLES);
        end
      end
      S_SQUASH: begin
        if (w_xfer) begin
          w_sq_nxt = r_sq_cnt - SQ_W'(1);
          if (r_sq_cnt <= SQ_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_sq_nxt    = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sq_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sq_cnt      <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 7'd0;
      r_err         <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sq_cnt   <= w_sq_nxt;
      r_redirect <= w_take;
      if (w_take) r_redirect_pc <= ex_branch;
      if (w_illegal) r_err <= 1'b1;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{rd: ex_rd, data: ex_result, op: ex_opcode};
  end

  assign w_yidx  = r_wptr - PTR_W'(1);
  assign w_head  = r_mem[r_rptr];
  assign w_young = r_mem[w_yidx];

  assign wb_valid    = (r_count != '0);
  assign wb_rd       = wb_valid ? w_head.rd   : 7'd0;
  assign wb_data     = wb_valid ? w_head.data : '0;
  assign wb_opcode   = wb_valid ? w_head.op   : 5'd0;
  assign fwd_valid   = wb_valid;
  assign fwd_rd      = fwd_valid ? w_young.rd   : 7'd0;
  assign fwd_data    = fwd_valid ? w_young.data : '0;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign flush       = w_flush;
  assign count       = r_count;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed vector bench for ex_wb_stage (DEPTH=2, FLUSH_CYCLES=2, DATA_W=32).
module tb_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_opcode;
  logic [6:0]  ex_rd, ex_branch;
  logic [31:0] ex_result;
  logic        wb_valid, wb_ready;
  logic [6:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  wb_opcode;
  logic        redirect, flush, fwd_valid, err_illegal;
  logic [6:0]  redirect_pc, fwd_rd;
  logic [31:0] fwd_data;
  logic [1:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  ex_wb_stage #(.DEPTH(2), .FLUSH_CYCLES(2), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .ex_branch(ex_branch), .ex_result(ex_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_opcode(wb_opcode),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .count(count), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [4:0]  op;
    logic [6:0]  rd;
    logic [6:0]  br;
    logic [31:0] res;
    logic        wbr;
    logic [1:0]  e_count;
    logic        e_wbv;
    logic [6:0]  e_wbrd;
    logic [31:0] e_wbdata;
    logic        e_fwdv;
    logic [6:0]  e_fwdrd;
    logic [31:0] e_fwddata;
    logic        e_redir;
    logic [6:0]  e_rpc;
    logic        e_flush;
    logic        e_err;
    logic        e_rdy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs, clock it, then compare the post-edge state.
  task automatic run_vec(input string tag, input vec_t v);
    rst = v.rst; ex_valid = v.vld; ex_opcode = v.op; ex_rd = v.rd;
    ex_branch = v.br; ex_result = v.res; wb_ready = v.wbr;
    @(posedge clk);
    #1;
    chk({tag, ".count"},     32'(count),       32'(v.e_count));
    chk({tag, ".wb_valid"},  32'(wb_valid),    32'(v.e_wbv));
    chk({tag, ".wb_rd"},     32'(wb_rd),       32'(v.e_wbrd));
    chk({tag, ".wb_data"},   wb_data,          v.e_wbdata);
    chk({tag, ".fwd_valid"}, 32'(fwd_valid),   32'(v.e_fwdv));
    chk({tag, ".fwd_rd"},    32'(fwd_rd),      32'(v.e_fwdrd));
    chk({tag, ".fwd_data"},  fwd_data,         v.e_fwddata);
    chk({tag, ".redirect"},  32'(redirect),    32'(v.e_redir));
    if (v.e_redir) chk({tag, ".redirect_pc"}, 32'(redirect_pc), 32'(v.e_rpc));
    chk({tag, ".flush"},     32'(flush),       32'(v.e_flush));
    chk({tag, ".err"},       32'(err_illegal), 32'(v.e_err));
    chk({tag, ".ex_ready"},  32'(ex_ready),    32'(v.e_rdy));
  endtask

  vec_t vecs [25];

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_rd = '0;
    ex_branch = '0; ex_result = '0; wb_ready = 1'b0;

    //        rst vld op  rd  br     res       wbr cnt wbv wbrd wbdata    fv frd fdata     rd  rpc    fl er rdy
    vecs[0]  = '{1, 0, 0,  0, 0,     0,        0,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[1]  = '{0, 1, 5,  3, 0,     7,        1,  1,  1,  3,   7,        1, 3,  7,        0, 0,     0, 0, 1};
    vecs[2]  = '{0, 0, 0,  0, 0,     0,        1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[3]  = '{0, 1, 2,  1, 0,     10,       0,  1,  1,  1,   10,       1, 1,  10,       0, 0,     0, 0, 1};
    vecs[4]  = '{0, 1, 4,  2, 0,     20,       0,  2,  1,  1,   10,       1, 2,  20,       0, 0,     0, 0, 0};
    vecs[5]  = '{0, 1, 9,  4, 0,     30,       0,  2,  1,  1,   10,       1, 2,  20,       0, 0,     0, 0, 0};
    vecs[6]  = '{0, 0, 0,  0, 0,     0,        1,  1,  1,  2,   20,       1, 2,  20,       0, 0,     0, 0, 1};
    vecs[7]  = '{0, 0, 0,  0, 0,     0,        1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[8]  = '{0, 1, 7,  0, 7'h2A, 0,        1,  0,  0,  0,   0,        0, 0,  0,        1, 7'h2A, 1, 0, 1};
    vecs[9]  = '{0, 1, 5,  5, 0,     55,       1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     1, 0, 1};
    vecs[10] = '{0, 1, 8,  0, 5,     0,        1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[11] = '{0, 0, 0,  0, 0,     0,        1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[12] = '{0, 1, 8,  0, 0,     0,        1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[13] = '{0, 1, 8,  0, 7'h11, 0,        1,  0,  0,  0,   0,        0, 0,  0,        1, 7'h11, 1, 0, 1};
    vecs[14] = '{0, 0, 0,  0, 0,     0,        1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     1, 0, 1};
    vecs[15] = '{0, 1, 1,  6, 0,     66,       1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     1, 0, 1};
    vecs[16] = '{0, 1, 10, 6, 0,     66,       1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[17] = '{0, 1, 0,  6, 0,     66,       1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[18] = '{0, 1, 15, 7, 0,     77,       1,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 1, 1};
    vecs[19] = '{0, 1, 3,  0, 0,     32'hDEAD, 0,  1,  1,  0,   32'hDEAD, 1, 0,  32'hDEAD, 0, 0,     0, 1, 1};
    vecs[20] = '{0, 1, 7,  0, 7'h33, 0,        0,  1,  1,  0,   32'hDEAD, 1, 0,  32'hDEAD, 1, 7'h33, 1, 1, 1};
    vecs[21] = '{1, 0, 0,  0, 0,     0,        0,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[22] = '{0, 1, 2,  1, 0,     1,        0,  1,  1,  1,   1,        1, 1,  1,        0, 0,     0, 0, 1};
    vecs[23] = '{1, 1, 7,  0, 7'h44, 0,        0,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};
    vecs[24] = '{0, 0, 0,  0, 0,     0,        0,  0,  0,  0,   0,        0, 0,  0,        0, 0,     0, 0, 1};

    for (int i = 0; i < 25; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Simultaneous push/pop, pointer wrap, and full-with-pop refusing a push.
    run_vec("h0", '{0, 1, 1, 1, 0, 32'h100, 0, 1, 1, 1, 32'h100, 1, 1, 32'h100, 0, 0, 0, 0, 1});
    run_vec("h1", '{0, 1, 2, 2, 0, 32'h200, 1, 1, 1, 2, 32'h200, 1, 2, 32'h200, 0, 0, 0, 0, 1});
    run_vec("h2", '{0, 1, 3, 3, 0, 32'h300, 0, 2, 1, 2, 32'h200, 1, 3, 32'h300, 0, 0, 0, 0, 0});
    run_vec("h3", '{0, 1, 5, 4, 0, 32'h400, 1, 1, 1, 3, 32'h300, 1, 3, 32'h300, 0, 0, 0, 0, 1});
    chk("h3.wb_opcode", 32'(wb_opcode), 32'd3);
    run_vec("h4", '{0, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 1});
    chk("h4.wb_opcode", 32'(wb_opcode), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
